// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel MMIO PWM with shared prescaled counter, edge/centre modes and shadowed duty/period
module pwm_bank #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int PRE_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                wren,
  input  logic [3:0]          adr,
  input  logic [31:0]         di,
  output logic [31:0]         dout,
  output logic [CHANNELS-1:0] out,
  output logic                wrap,
  output logic                irq
);
  logic en_q, en_d, mode_q, mode_d, irq_en_q, irq_en_d, flag_q, flag_d;
  logic dir_q, dir_d, wrap_q, wrap_d, tick, evt;
  logic [WIDTH-1:0] period_q, period_d, per_act_q, per_act_d, cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d, psc_q, psc_d;
  logic [CHANNELS-1:0] pol_q, pol_d, out_q, out_d;
  logic [CHANNELS-1:0][WIDTH-1:0] duty_q, duty_d, duty_act_q, duty_act_d;
  logic [31:0] dout_q, dout_d, rdat;
  logic [15:0] wsel;
  logic unused_di;
  assign unused_di = ^di;
  assign wsel = (cs && wren) ? 16'd1 << adr : 16'd0;
  // bus writes into the programmable registers; a clear-on-write loses to a coincident event
  always_comb begin
    {irq_en_d, mode_d, en_d} = wsel[0] ? di[2:0] : {irq_en_q, mode_q, en_q};
    period_d = wsel[1] ? di[WIDTH-1:0] : period_q;
    pre_d = wsel[2] ? di[PRE_W-1:0] : pre_q;
    pol_d = wsel[5] ? di[CHANNELS-1:0] : pol_q;
    flag_d = evt | (flag_q & ~(wsel[3] & di[0]));
    for (int i = 0; i < CHANNELS; i++) duty_d[i] = wsel[8+i] ? di[WIDTH-1:0] : duty_q[i];
  end
  // prescaler and shared counter; a prescaler above a freshly lowered limit restarts without ticking
  always_comb begin
    tick = en_q && psc_q == pre_q;
    psc_d = (!en_q || psc_q >= pre_q) ? '0 : psc_q + PRE_W'(1);
    cnt_d = cnt_q;
    dir_d = dir_q;
    evt = 1'b0;
    if (!en_q) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick && !mode_q) begin
      evt = cnt_q >= per_act_q;
      cnt_d = evt ? '0 : cnt_q + WIDTH'(1);
    end else if (tick && per_act_q == '0) begin
      evt = 1'b1;
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick && !dir_q) begin
      dir_d = cnt_q >= per_act_q;
      cnt_d = dir_d ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
    end else if (tick) begin
      evt = cnt_q <= WIDTH'(1);
      cnt_d = evt ? '0 : cnt_q - WIDTH'(1);
      dir_d = !evt;
    end
  end
  // shadows follow the registers while idle and reload only at the period event while running
  always_comb begin
    per_act_d = (!en_q || evt) ? period_q : per_act_q;
    duty_act_d = (!en_q || evt) ? duty_q : duty_act_q;
    wrap_d = evt;
    for (int i = 0; i < CHANNELS; i++) out_d[i] = pol_q[i] ^ (en_q && cnt_q < duty_act_q[i]);
  end
  // read mux; anything unmapped or past the last channel reads as zero
  always_comb begin
    rdat = '0;
    case (adr)
      4'd0: rdat = {29'd0, irq_en_q, mode_q, en_q};
      4'd1: rdat = 32'(period_q);
      4'd2: rdat = 32'(pre_q);
      4'd3: rdat = {31'd0, flag_q};
      4'd4: rdat = 32'(cnt_q);
      4'd5: rdat = 32'(pol_q);
      default: ;
    endcase
    for (int i = 0; i < CHANNELS; i++) if (adr == 4'(8 + i)) rdat = 32'(duty_q[i]);
    dout_d = (cs && !wren) ? rdat : '0;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      {en_q, mode_q, irq_en_q, flag_q, dir_q, wrap_q} <= '0;
      {period_q, per_act_q, cnt_q} <= '0;
      {pre_q, psc_q} <= '0;
      {pol_q, out_q} <= '0;
      duty_q <= '0;
      duty_act_q <= '0;
      dout_q <= '0;
    end else begin
      {en_q, mode_q, irq_en_q, flag_q, dir_q, wrap_q} <= {en_d, mode_d, irq_en_d, flag_d, dir_d, wrap_d};
      {period_q, per_act_q, cnt_q} <= {period_d, per_act_d, cnt_d};
      {pre_q, psc_q} <= {pre_d, psc_d};
      {pol_q, out_q} <= {pol_d, out_d};
      duty_q <= duty_d;
      duty_act_q <= duty_act_d;
      dout_q <= dout_d;
    end
  end
  assign dout = dout_q;
  assign out = out_q;
  assign wrap = wrap_q;
  assign irq = flag_q & irq_en_q;
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed scoreboard bench for the pwm_bank MMIO peripheral
module tb_pwm_bank;
  logic clk = 0, reset = 1, cs = 0, wren = 0;
  logic [3:0] adr = '0;
  logic [31:0] di = '0;
  logic [31:0] dout;
  logic [2:0] out;
  logic wrap, irq;
  typedef struct { string name; int kind; logic [31:0] exp; } item_t;
  item_t rdq[$];
  item_t pq[$];
  int errors = 0, checks = 0;
  logic vld = 0, done = 0;
  logic [9:0] epat = 10'h007;
  logic [15:0] cpat = 16'hC00F;
  int ctab[16] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1};

  pwm_bank #(.CHANNELS(3), .WIDTH(8), .PRE_W(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wren(wren), .adr(adr), .di(di),
    .dout(dout), .out(out), .wrap(wrap), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sample(input int k);
    return k == 0 ? dout : k == 1 ? 32'(wrap) : k == 2 ? 32'(irq) : k == 6 ? 32'(out) : 32'(out[k-3]);
  endfunction

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(posedge clk) vld <= cs && !wren && !reset;

  always @(negedge clk) begin
    item_t it;
    if (vld) begin
      if (rdq.size() == 0) cmp("rd_underflow", dout, 32'hDEAD_BEEF);
      else begin
        it = rdq.pop_front();
        cmp(it.name, dout, it.exp);
      end
    end
    while (pq.size() > 0) begin
      it = pq.pop_front();
      cmp(it.name, sample(it.kind), it.exp);
    end
    if (done) begin
      cmp("rdq_drain", rdq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cs = 1; wren = 1; adr = a; di = d;
    step();
    cs = 0; wren = 0;
  endtask

  task automatic rd(input string n, input logic [3:0] a, input logic [31:0] e);
    cs = 1; wren = 0; adr = a;
    rdq.push_back('{name: n, kind: 0, exp: e});
    step();
    cs = 0;
  endtask

  task automatic probe(input string n, input int k, input logic [31:0] e);
    pq.push_back('{name: n, kind: k, exp: e});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    reset = 0;
    probe("rst_out", 6, 0); probe("rst_wrap", 1, 0); probe("rst_irq", 2, 0); probe("rst_dout", 0, 0);
    rd("rst_ctrl", 0, 0);
    rd("rst_count", 4, 0);
    // edge mode, period 10, duty 3
    wr(2, 0); wr(1, 9); wr(8, 3); wr(5, 0); wr(0, 1);
    for (int n = 1; n <= 20; n++) begin
      step();
      probe("edge_out0", 3, 32'(epat[(n-1)%10]));
      probe("edge_wrap", 1, 32'(n % 10 == 0));
    end
    for (int i = 0; i < 10; i++) rd("edge_count", 4, i);
    // duty update mid-period takes effect only after the next event
    step(); step();
    wr(8, 7);
    for (int n = 34; n <= 50; n++) begin
      step();
      probe("shadow_out0", 3, 32'((n-1) % 10 < (n <= 40 ? 3 : 7)));
    end
    // limits: duty 0 low, duty period+1 high, polarity inverts
    wr(10, 10);
    repeat (10) step();
    for (int i = 0; i < 10; i++) begin
      step();
      probe("duty0_low", 4, 0); probe("dutymax_high", 5, 1);
    end
    wr(5, 6);
    for (int i = 0; i < 10; i++) begin
      step();
      probe("pol_duty0", 4, 1); probe("pol_dutymax", 5, 0);
    end
    wr(0, 0);
    step();
    probe("dis_out_pol", 6, 6);
    rd("dis_count", 4, 0);
    // centre mode, period 4, prescale 1
    wr(5, 0); wr(10, 0); wr(1, 4); wr(9, 2); wr(2, 1); wr(0, 3);
    for (int n = 1; n <= 32; n++) begin
      step();
      probe("ctr_out1", 4, 32'(cpat[(n-1)%16]));
      probe("ctr_wrap", 1, 32'(n % 16 == 0));
    end
    for (int i = 0; i < 16; i++) rd("ctr_count", 4, ctab[i]);
    // interrupt: set, set-wins-over-clear, quiet clear
    wr(0, 7);
    wr(3, 1);
    probe("irq_cleared", 2, 0);
    repeat (13) step();
    probe("irq_pre", 2, 0);
    step();
    probe("irq_set", 2, 1); probe("irq_wrap", 1, 1);
    repeat (15) step();
    wr(3, 1);
    probe("irq_setwins", 2, 1); probe("irq_wrap2", 1, 1);
    wr(3, 1);
    probe("irq_quiet_clr", 2, 0);
    rd("status", 3, 0);
    // bus behaviour
    rd("unmapped6", 6, 0);
    rd("duty_oob", 11, 0);
    rd("period", 1, 4);
    step();
    probe("dout_idle", 0, 0);
    rd("ctrl", 0, 7);
    rd("prescale", 2, 1);
    rd("duty1", 9, 2);
    rd("duty0", 8, 7);
    wr(2, 32'h0000_0301);
    probe("dout_wr", 0, 0);
    rd("prescale_trunc", 2, 1);
    // reset mid-run beats a simultaneous write
    reset = 1; cs = 1; wren = 1; adr = 0; di = 7;
    step();
    reset = 0; cs = 0; wren = 0;
    probe("mrst_out", 6, 0); probe("mrst_wrap", 1, 0); probe("mrst_irq", 2, 0); probe("mrst_dout", 0, 0);
    rd("mrst_ctrl", 0, 0);
    rd("mrst_period", 1, 0);
    rd("mrst_count", 4, 0);
    rd("mrst_duty0", 8, 0);
    done = 1;
    step();
    step();
  end
endmodule
